// File: rtl/pipeline_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_host_pkg
//  Description : Shared definitions for the pipeline host command engine:
//                opcodes, response status codes, header layout and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_host_pkg;

  // Command opcodes carried in header bits [31:28]
  localparam logic [3:0] OP_LOAD_IMEM = 4'd1;
  localparam logic [3:0] OP_LOAD_DMEM = 4'd2;
  localparam logic [3:0] OP_READ_DMEM = 4'd3;
  localparam logic [3:0] OP_RUN       = 4'd4;

  // Response status tags
  localparam logic [1:0] ST_DATA        = 2'd0;
  localparam logic [1:0] ST_RUN_HIT     = 2'd1;
  localparam logic [1:0] ST_RUN_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BAD_OP      = 2'd3;

  // FSM state encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RSP     = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;

  // Header word layout: [31:28] op, [27:16] count, [15:9] reserved, [8:0] base
  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] count;
    logic [6:0]  rsvd;
    logic [8:0]  base;
  } hdr_t;

  // True for the two memory-load opcodes
  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LOAD_IMEM) || (op == OP_LOAD_DMEM);
  endfunction

  // True for any opcode the engine understands
  function automatic logic op_is_known(input logic [3:0] op);
    return op_is_load(op) || (op == OP_READ_DMEM) || (op == OP_RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_host_ctrl
//  Description : Host-side command engine for the five-stage pipeline. Takes
//                header/payload words on a valid/ready stream, drives the
//                imem/dmem load strobes, dmem readback and the core reset/run
//                control, and returns tagged 32-bit result words.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_host_ctrl
  import pipeline_host_pkg::*;
#(
  parameter int          RD_LAT       = 1,             // dmem read latency, 1..4
  parameter logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  // pipeline controls
  output logic        core_rst,
  output logic        write_to_imem,
  output logic        write_to_dmem,
  output logic [8:0]  addr_imem_host,
  output logic [31:0] data_imem_host,
  output logic [7:0]  addr_dmem_host,
  output logic [31:0] data_dmem_host,
  output logic        read_req_dmem,
  input  logic [31:0] data_out_dmem,
  input  logic        alu_result_detected,
  input  logic [31:0] alu_out_intercept,
  output logic        busy
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  hdr_t        w_hdr;
  logic        w_cmd_fire;
  logic        w_rsp_fire;
  logic        w_run_hit;
  logic        w_run_limit;
  logic        w_unused_hdr;

  logic [3:0]  r_op;       // opcode of the command in flight
  logic [11:0] r_cnt;      // words remaining (load/read) or cycle limit (run)
  logic [8:0]  r_addr;     // running memory address
  logic [11:0] r_cyc;      // run-cycle index, 1 on the first run cycle
  logic [1:0]  r_wait;     // read-latency countdown

  logic        r_core_rst;
  logic        r_busy;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_status;
  logic        r_wr_imem;
  logic        r_wr_dmem;
  logic [8:0]  r_addr_imem;
  logic [31:0] r_data_imem;
  logic [7:0]  r_addr_dmem;
  logic [31:0] r_data_dmem;
  logic        r_read_req;

  assign w_hdr        = hdr_t'(cmd_data);
  assign w_unused_hdr = &{1'b0, w_hdr.rsvd};

  // Ready is a pure decode of the registered state, forced low while in reset
  assign cmd_ready  = rst_n & ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;

  // The store-observe tap only counts while the core is actually running
  assign w_run_hit   = (r_state == S_RUN) & ~r_core_rst & alu_result_detected;
  assign w_run_limit = (r_state == S_RUN) & (r_cnt != 12'd0) & (r_cyc == r_cnt);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          if (op_is_load(w_hdr.op)) begin
            w_state_nxt = (w_hdr.count == 12'd0) ? S_IDLE : S_LOAD;
          end else if (w_hdr.op == OP_READ_DMEM) begin
            w_state_nxt = (w_hdr.count == 12'd0) ? S_IDLE : S_RD_REQ;
          end else if (w_hdr.op == OP_RUN) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_RSP;
          end
        end
      end
      S_LOAD: begin
        if (w_cmd_fire && (r_cnt == 12'd1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_REQ: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_wait == 2'd0) begin
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (w_rsp_fire) begin
          w_state_nxt = ((r_op == OP_READ_DMEM) && (r_cnt > 12'd1)) ? S_RD_REQ : S_IDLE;
        end
      end
      S_RUN: begin
        // hit and limit share the exit; the datapath gives the hit priority
        if (w_run_hit || w_run_limit) begin
          w_state_nxt = S_RSP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the control outputs that follow directly from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_core_rst  <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_read_req  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_core_rst  <= (w_state_nxt != S_RUN);
      r_rsp_valid <= (w_state_nxt == S_RSP);
      r_read_req  <= (w_state_nxt == S_RD_REQ);
    end
  end

  // Command datapath: field latching, address walk, strobes and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= 4'd0;
      r_cnt        <= 12'd0;
      r_addr       <= 9'd0;
      r_cyc        <= 12'd0;
      r_wait       <= 2'd0;
      r_rsp_data   <= 32'd0;
      r_rsp_status <= 2'd0;
      r_wr_imem    <= 1'b0;
      r_wr_dmem    <= 1'b0;
      r_addr_imem  <= 9'd0;
      r_data_imem  <= 32'd0;
      r_addr_dmem  <= 8'd0;
      r_data_dmem  <= 32'd0;
    end else begin
      r_wr_imem <= 1'b0;
      r_wr_dmem <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_op  <= w_hdr.op;
            r_cnt <= w_hdr.count;
            r_cyc <= 12'd1;
            // dmem addresses are only 8 bits wide, so drop base[8] up front
            r_addr <= (w_hdr.op == OP_LOAD_IMEM) ? w_hdr.base : {1'b0, w_hdr.base[7:0]};
            if (w_hdr.op == OP_READ_DMEM) begin
              r_addr_dmem <= w_hdr.base[7:0];
            end
            if (!op_is_known(w_hdr.op)) begin
              r_rsp_data   <= cmd_data;
              r_rsp_status <= ST_BAD_OP;
            end
          end
        end
        S_LOAD: begin
          if (w_cmd_fire) begin
            r_cnt <= r_cnt - 12'd1;
            if (r_op == OP_LOAD_IMEM) begin
              r_wr_imem   <= 1'b1;
              r_addr_imem <= r_addr;
              r_data_imem <= cmd_data;
              r_addr      <= r_addr + 9'd1;
            end else begin
              r_wr_dmem   <= 1'b1;
              r_addr_dmem <= r_addr[7:0];
              r_data_dmem <= cmd_data;
              r_addr      <= {1'b0, r_addr[7:0] + 8'd1};
            end
          end
        end
        S_RD_REQ: begin
          r_wait <= 2'(RD_LAT - 1);
        end
        S_RD_WAIT: begin
          if (r_wait == 2'd0) begin
            r_rsp_data   <= data_out_dmem;
            r_rsp_status <= ST_DATA;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_RSP: begin
          // response fields are left untouched here so they hold while stalled
          if (w_rsp_fire && (r_op == OP_READ_DMEM) && (r_cnt > 12'd1)) begin
            r_cnt       <= r_cnt - 12'd1;
            r_addr      <= {1'b0, r_addr[7:0] + 8'd1};
            r_addr_dmem <= r_addr[7:0] + 8'd1;
          end
        end
        S_RUN: begin
          r_cyc <= r_cyc + 12'd1;
          if (w_run_hit) begin
            r_rsp_data   <= alu_out_intercept;
            r_rsp_status <= ST_RUN_HIT;
          end else if (w_run_limit) begin
            r_rsp_data   <= TIMEOUT_WORD;
            r_rsp_status <= ST_RUN_TIMEOUT;
          end
        end
        default: begin
          r_wait <= 2'd0;
        end
      endcase
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_status     = r_rsp_status;
  assign core_rst       = r_core_rst;
  assign busy           = r_busy;
  assign write_to_imem  = r_wr_imem;
  assign write_to_dmem  = r_wr_dmem;
  assign addr_imem_host = r_addr_imem;
  assign data_imem_host = r_data_imem;
  assign addr_dmem_host = r_addr_dmem;
  assign data_dmem_host = r_data_dmem;
  assign read_req_dmem  = r_read_req;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_host_ctrl
//  Description : Scoreboard bench for pipeline_host_ctrl. Stimulus tasks push
//                expected writes/responses derived from the command rules;
//                a monitor process pops and compares as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_host_ctrl;

  localparam int          RD_LAT = 2;
  localparam logic [31:0] TW     = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        core_rst;
  logic        write_to_imem;
  logic        write_to_dmem;
  logic [8:0]  addr_imem_host;
  logic [31:0] data_imem_host;
  logic [7:0]  addr_dmem_host;
  logic [31:0] data_dmem_host;
  logic        read_req_dmem;
  logic [31:0] data_out_dmem;
  logic        alu_result_detected;
  logic [31:0] alu_out_intercept;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  logic tb_mem_init;

  // expected traffic: imem {addr,data}, dmem {addr,data}, responses {status,data}
  logic [40:0] q_imem [$];
  logic [39:0] q_dmem [$];
  logic [33:0] q_rsp  [$];
  logic [31:0] ref_dmem [256];

  pipeline_host_ctrl #(.RD_LAT(RD_LAT), .TIMEOUT_WORD(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .core_rst(core_rst), .write_to_imem(write_to_imem), .write_to_dmem(write_to_dmem),
    .addr_imem_host(addr_imem_host), .data_imem_host(data_imem_host),
    .addr_dmem_host(addr_dmem_host), .data_dmem_host(data_dmem_host),
    .read_req_dmem(read_req_dmem), .data_out_dmem(data_out_dmem),
    .alu_result_detected(alu_result_detected), .alu_out_intercept(alu_out_intercept),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    if (i == 4) return 32'h11;
    if (i == 5) return 32'h22;
    return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0F0F;
  endfunction

  // Data memory environment model with an RD_LAT-deep read pipeline
  logic [31:0] env_dmem [256];
  logic [31:0] rd_pipe  [RD_LAT];
  always @(posedge clk) begin
    if (tb_mem_init) begin
      for (int i = 0; i < 256; i++) env_dmem[i] <= mem_init(i);
    end else if (write_to_dmem) begin
      env_dmem[addr_dmem_host] <= data_dmem_host;
    end
    if (read_req_dmem) rd_pipe[0] <= env_dmem[addr_dmem_host];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign data_out_dmem = rd_pipe[RD_LAT-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Response back-pressure: random, with forced stall windows
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        rsp_ready = 1'b0;
        stall_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares every emitted strobe/response against the scoreboard
  initial begin
    logic        prev_stall;
    logic [33:0] prev_rsp;
    prev_stall = 1'b0;
    prev_rsp   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (write_to_imem) begin
          if (q_imem.size() == 0) fail_now("imem_write_unexpected");
          else begin
            check("imem_write", {addr_imem_host, data_imem_host}, q_imem[0]);
            void'(q_imem.pop_front());
          end
        end
        if (write_to_dmem) begin
          if (q_dmem.size() == 0) fail_now("dmem_write_unexpected");
          else begin
            check("dmem_write", {addr_dmem_host, data_dmem_host}, q_dmem[0]);
            void'(q_dmem.pop_front());
          end
        end
        if (prev_stall) check("rsp_hold_stable", {rsp_valid, rsp_status, rsp_data}, {1'b1, prev_rsp});
        if (rsp_valid && rsp_ready) begin
          if (q_rsp.size() == 0) fail_now("rsp_unexpected");
          else begin
            check("rsp_word", {rsp_status, rsp_data}, q_rsp[0]);
            void'(q_rsp.pop_front());
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_status, rsp_data};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Present one word and return one cycle after its handshake edge (+1)
  task automatic send_word(input logic [31:0] w, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    cmd_valid = 1'b1;
    cmd_data  = w;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        return;
      end
    end
    cmd_valid = 1'b0;
    fail_now("cmd_handshake_timeout");
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!busy && q_rsp.size() == 0 && q_imem.size() == 0 && q_dmem.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    fail_now("wait_idle_timeout");
  endtask

  task automatic do_load(input bit imem, input logic [8:0] base, input int cnt, input int maxgap);
    logic [31:0] w [$];
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] v;
      logic [7:0]  a;
      v = $urandom;
      w.push_back(v);
      if (imem) q_imem.push_back({9'((int'(base) + i) % 512), v});
      else begin
        a = 8'((int'(base[7:0]) + i) % 256);
        q_dmem.push_back({a, v});
        ref_dmem[a] = v;
      end
    end
    send_word({(imem ? 4'd1 : 4'd2), 12'(cnt), 7'd0, base}, $urandom_range(0, maxgap));
    for (int i = 0; i < cnt; i++) send_word(w[i], $urandom_range(0, maxgap));
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] base, input int cnt, input bit timing);
    for (int i = 0; i < cnt; i++) q_rsp.push_back({2'd0, ref_dmem[(int'(base) + i) % 256]});
    send_word({4'd3, 12'(cnt), 8'd0, base}, timing ? 0 : $urandom_range(0, 2));
    if (timing) begin
      stall_cnt = RD_LAT + 4;
      @(negedge clk);
      check("read_req_next_cycle", {read_req_dmem, addr_dmem_host}, {1'b1, base});
      repeat (RD_LAT) @(negedge clk);
      check("read_rsp_not_early", rsp_valid, 1'b0);
      @(negedge clk);
      check("read_rsp_latency", rsp_valid, 1'b1);
      @(posedge clk); #1;
    end
    wait_idle();
  endtask

  task automatic do_run(input int c, input int k, input logic [31:0] val);
    bit hit;
    int e;
    hit = (k != 0) && (c == 0 || k <= c);
    e   = hit ? k : c;
    q_rsp.push_back(hit ? {2'd1, val} : {2'd2, TW});
    send_word({4'd4, 12'(c), 16'd0}, 0);
    for (int j = 1; j <= e; j++) begin
      if (j == k) begin
        alu_result_detected = 1'b1;
        alu_out_intercept   = val;
      end
      @(negedge clk);
      check("run_core_rst_low", core_rst, 1'b0);
      @(posedge clk); #1;
      alu_result_detected = 1'b0;
      alu_out_intercept   = $urandom;
    end
    @(negedge clk);
    check("run_end_core_rst_high", core_rst, 1'b1);
    check("run_end_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    wait_idle();
  endtask

  task automatic do_bad(input logic [3:0] op);
    logic [31:0] r;
    logic [31:0] h;
    r = $urandom;
    h = {op, r[27:0]};
    q_rsp.push_back({2'd3, h});
    send_word(h, $urandom_range(0, 2));
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    tb_mem_init = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    alu_result_detected = 1'b0;
    alu_out_intercept = '0;
    for (int i = 0; i < 256; i++) ref_dmem[i] = mem_init(i);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {write_to_imem, write_to_dmem, read_req_dmem, rsp_valid}, 4'b0);
    check("rst_addr_data", {addr_imem_host, addr_dmem_host, rsp_data, rsp_status}, 51'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_mem_init = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // directed cases
    do_load(1'b1, 9'h010, 3, 0);
    do_load(1'b0, 9'h0FF, 2, 1);
    do_read(8'h04, 2, 1'b1);
    // detect while idle must be ignored
    alu_result_detected = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    alu_result_detected = 1'b0;
    @(negedge clk);
    check("idle_detect_ignored", {rsp_valid, core_rst, busy}, 3'b010);
    @(posedge clk); #1;
    do_run(100, 10, 32'h0000_002A);
    do_run(5, 0, 32'h0);
    do_run(5, 5, 32'h1234_5678);
    do_run(5, 6, 32'h0BAD_0BAD);
    do_bad(4'h7);
    do_bad(4'h0);
    do_load(1'b1, 9'h1FE, 0, 0);
    do_read(8'h10, 0, 1'b0);

    // reset in the middle of an imem load
    begin
      logic [31:0] w0;
      w0 = $urandom;
      q_imem.push_back({9'h100, w0});
      send_word(32'h1004_0100, 0);
      send_word(w0, 0);
      send_word($urandom, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {write_to_imem, write_to_dmem, core_rst, busy, cmd_ready, rsp_valid}, 6'b001000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_no_pending_write", q_imem.size(), 0);
      @(negedge clk);
      check("midrst_back_idle", {busy, cmd_ready, core_rst}, 3'b011);
      @(posedge clk); #1;
    end

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: do_load(1'b1, 9'($urandom), $urandom_range(0, 6), 2);
        1: do_load(1'b0, 9'($urandom), $urandom_range(0, 6), 2);
        2: do_read(8'($urandom), $urandom_range(0, 4), 1'b0);
        3: begin
          int c;
          c = $urandom_range(0, 20);
          do_run(c, (c == 0) ? $urandom_range(1, 20) : $urandom_range(0, 25), $urandom);
        end
        default: do_bad(4'($urandom_range(5, 15)));
      endcase
    end

    wait_idle();
    check("final_queues_empty", q_imem.size() + q_dmem.size() + q_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
